// File: rtl/sync_fifo_ctrl_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_ctrl_if
//   Bundles the producer/consumer handshake and status signals of
//   sync_fifo_ctrl so the FIFO and its users connect through one port.
//
//   master : the side that writes and reads the FIFO (drives wr_en/din/rd_en)
//   slave  : the FIFO itself (drives dout and all status outputs)
//
//   wr_en, din    write request and write data
//   rd_en         read request (pop/acknowledge in first-word-fall-through)
//   dout          read data
//   full, empty, almost_full, almost_empty   registered occupancy flags
//   count         entries held, $clog2(DEPTH+1) bits
//   overflow, underflow   one-cycle pulses for a rejected write / read
// ----------------------------------------------------------------------------
interface sync_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, din, rd_en,
      input  dout, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en,
      output dout, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// sync_fifo_ctrl
//   Parametrised single-clock FIFO with selectable read mode (standard with
//   one-cycle read latency, or first-word-fall-through), occupancy count,
//   static almost-full/almost-empty thresholds and overflow/underflow pulses.
//   DEPTH need not be a power of two; pointers wrap explicitly.
//
//   clk   rising-edge clock for all state
//   rst   synchronous, active-high reset (pointers, count, flags, dout)
//   fifo  sync_fifo_ctrl_if.slave: wr_en/din/rd_en in; dout, full, empty,
//         almost_full, almost_empty, count, overflow, underflow out
// ----------------------------------------------------------------------------
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 4,
   parameter int FWFT       = 0
) (
   input  logic              clk,
   input  logic              rst,
   sync_fifo_ctrl_if.slave   fifo
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   // Illegal configurations stop elaboration rather than silently misbehave.
   if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "sync_fifo_ctrl: DEPTH must be >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $fatal(1, "sync_fifo_ctrl: AF_LEVEL must be in 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $fatal(1, "sync_fifo_ctrl: AE_LEVEL must be in 0..DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q, af_q, ae_q;
   logic          overflow_q, underflow_q;
   logic          rd_acc, wr_acc;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + PW'(1);
   endfunction

   // A read of an empty FIFO is never accepted, even alongside a write.
   // A write to a full FIFO is accepted only when a read frees a slot
   // in the same cycle.
   assign rd_acc = fifo.rd_en & ~empty_q;
   assign wr_acc = fifo.wr_en & (~full_q | rd_acc);

   always_comb begin
      wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Flags are computed from next-state count so they line up with count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         af_q        <= 1'b0;
         ae_q        <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= (count_d == DEPTH_C);
         empty_q     <= (count_d == '0);
         af_q        <= (count_d >= AF_C);
         ae_q        <= (count_d <= AE_C);
         overflow_q  <= fifo.wr_en & ~wr_acc;
         underflow_q <= fifo.rd_en & ~rd_acc;
      end
   end

   // Storage is not reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wr_ptr_q] <= fifo.din;
      end
   end

   if (FWFT == 0) begin : g_std
      // Standard mode: registered output updated only by an accepted read.
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q <= '0;
         end else if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
         end
      end
      assign fifo.dout = dout_q;
   end else begin : g_fwft
      // Head word is presented directly; forced to zero while empty so the
      // output is deterministic after reset.
      assign fifo.dout = empty_q ? '0 : mem_q[rd_ptr_q];
   end

   assign fifo.full         = full_q;
   assign fifo.empty        = empty_q;
   assign fifo.almost_full  = af_q;
   assign fifo.almost_empty = ae_q;
   assign fifo.count        = count_q;
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

endmodule
